// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings, datapath width and the operand
// bundle that the arbiter hands to the single ALU instance.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    typedef struct packed {
        logic [3:0]      ctrl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant starting from a rotating
// priority pointer, which moves past the winner when advance_i is high.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr_q) + i) % N);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                if (advance_i) begin
                    ptr_d = PW'((int'(idx) + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters: round-robin issue of
// one op per cycle, result captured into a per-requester response slot.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int TAGW = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*32-1:0]   i_req_a,
    input  logic [NREQ*32-1:0]   i_req_b,
    input  logic [NREQ*4-1:0]    i_req_ctrl,
    input  logic [NREQ*TAGW-1:0] i_req_tag,
    output logic [NREQ-1:0]      o_rsp_valid,
    input  logic [NREQ-1:0]      i_rsp_ready,
    output logic [NREQ*32-1:0]   o_rsp_result,
    output logic [NREQ*TAGW-1:0] o_rsp_tag,
    output logic [31:0]          o_alu_a,
    output logic [31:0]          o_alu_b,
    output logic [3:0]           o_aluctrl_ctrl,
    input  logic [31:0]          i_alu_out
);

    import alu_pkg::*;

    logic [NREQ-1:0] rsp_valid;
    logic [NREQ-1:0] slot_free;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    alu_req_t        alu_sel;

    // A slot draining this cycle can take a new result on the same edge.
    assign slot_free = ~rsp_valid | i_rsp_ready;
    assign eligible  = i_req_valid & slot_free & {NREQ{i_rst_n}};

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .clk_i     (i_clk),
        .rst_n_i   (i_rst_n),
        .req_i     (eligible),
        .advance_i (|eligible),
        .grant_o   (grant)
    );

    assign o_req_ready = grant;

    always_comb begin
        alu_sel.ctrl = OP_ADD;
        alu_sel.a    = '0;
        alu_sel.b    = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (grant[r]) begin
                alu_sel.ctrl = i_req_ctrl[r*4 +: 4];
                alu_sel.a    = i_req_a[r*XLEN +: XLEN];
                alu_sel.b    = i_req_b[r*XLEN +: XLEN];
            end
        end
    end

    assign o_alu_a        = alu_sel.a;
    assign o_alu_b        = alu_sel.b;
    assign o_aluctrl_ctrl = alu_sel.ctrl;

    for (genvar r = 0; r < NREQ; r++) begin : g_slot
        logic            valid_q, valid_d;
        logic [XLEN-1:0] result_q, result_d;
        logic [TAGW-1:0] tag_q, tag_d;

        // A re-grant wins over a drain so a single requester streams 1/cycle.
        always_comb begin
            valid_d  = valid_q;
            result_d = result_q;
            tag_d    = tag_q;
            if (grant[r]) begin
                valid_d  = 1'b1;
                result_d = i_alu_out;
                tag_d    = i_req_tag[r*TAGW +: TAGW];
            end else if (i_rsp_ready[r]) begin
                valid_d  = 1'b0;
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                valid_q  <= 1'b0;
                result_q <= '0;
                tag_q    <= '0;
            end else begin
                valid_q  <= valid_d;
                result_q <= result_d;
                tag_q    <= tag_d;
            end
        end

        assign rsp_valid[r]                   = valid_q;
        assign o_rsp_result[r*XLEN +: XLEN]   = result_q;
        assign o_rsp_tag[r*TAGW +: TAGW]      = tag_q;
    end

    assign o_rsp_valid = rsp_valid;

endmodule
